vedic_mult_pipe: RTL
====================

Name: vedic_mult_pipe

Overview:
- Parametrised, pipelined successor of the team's 16x16 combinational Vedic multiplier.
- Multiplies two WIDTH-bit operands, signed or unsigned, selected per transaction.
- The product is built from four half-width Vedic partial products across three register stages.
- Uses a valid/ready stream on both sides with full backpressure, so it drops directly into the datapath between producer and accumulator blocks.

Parameters:
- WIDTH, 16: operand width. Must be a power of 2 and at least 4. Product width is 2*WIDTH.
- TAG_W, 4: width of the user tag carried alongside each operation.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_a  input  WIDTH  multiplicand
- in_b  input  WIDTH  multiplier
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned
- in_tag  input  TAG_W  user tag, returned unchanged with the result
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts the result
- out_p  output  2*WIDTH  product
- out_tag  output  TAG_W  tag of this product
- busy  output  1  at least one stage holds a valid beat

Behaviour:
- Reset (async assert, sync release):
  - all stage valid bits, out_valid and busy = 0.
  - out_p and out_tag = 0.
  - in_ready = 1 from the first cycle after reset release.
- Global pipeline enable: en = !out_valid || out_ready. Every stage advances only when en = 1.
- in_ready = en. A beat is accepted when in_valid && in_ready.
- Stage S1 (register): capture operands, tag and signed flag.
  - Signed mode: compute magnitudes |a| and |b|, each WIDTH bits unsigned (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits), plus neg = sign(a) XOR sign(b).
  - Unsigned mode: neg = 0 and operands pass through unchanged.
- Stage S2 (register): four half-width products of the magnitudes:
  - ll = aL*bL
  - hl = aH*bL
  - lh = aL*bH
  - hh = aH*bH
  - Each is WIDTH bits, produced by the vedic_mult_core sub-module.
- Stage S3 (output register):
  - mag = ll + (hl << WIDTH/2) + (lh << WIDTH/2) + (hh << WIDTH).
  - Summation is exact in 2*WIDTH bits; no carry is dropped.
  - out_p = neg ? (~mag + 1) : mag.
- Latency: an accepted beat appears on out_valid exactly 3 cycles later when there is no stall. Throughput is 1 beat/cycle.
- Backpressure: while out_valid && !out_ready, every stage holds and out_p/out_tag stay stable. No beat is lost or duplicated.
- Bubbles: invalid beats travel through the pipeline. Stage data registers are not updated for invalid beats, which saves power; outputs must not toggle while out_valid = 0.
- Ordering: results leave in acceptance order. out_tag always matches its operands.
- Zero operand in either mode: result is 0, and no negative zero is possible.
- Simultaneous accept and emit in one cycle is legal and required for full throughput.
- busy = OR of the S1/S2/S3 valid bits.
- Reset mid-operation: all in-flight beats are discarded and no out_valid is produced for them. A beat presented in the cycle reset is released is not accepted.

Decomposition:
- Package vedic_pkg:
  - function for product width (2*WIDTH)
  - compile-time check that WIDTH is a power of 2 and at least 4
  - localparam HALF = WIDTH/2
- Sub-module vedic_mult_core #(N):
  - combinational unsigned NxN to 2N Vedic multiplier.
  - Recursive split into four N/2 cores plus an adder tree; base case 2x2 from AND/half-adders.
  - Instantiated four times with N = HALF.
- The top level holds only the pipeline registers, sign logic, the final sum and the handshake.

Test Plan:
- Unsigned single beat: a=125, b=10, signed=0, tag=3 -> out_p=1250 (0x000004E2), out_tag=3, out_valid exactly 3 cycles after accept.
- Unsigned extremes: 0xFFFF*0xFFFF -> 0xFFFE0001; 0x0000*0xBEEF -> 0. Run back-to-back so one result is produced per cycle.
- Signed corners:
  - 0xFFFF*0xFFFF (-1*-1) -> 0x00000001
  - 0x8000*0x8000 -> 0x40000000
  - 0x8000*0x0001 -> 0xFFFF8000
  - 0x7FFF*0x8000 -> 0xC0008000
- Backpressure: stream 8 beats with tags 0..7 while out_ready toggles randomly and is held low for 5 cycles -> exactly 8 results in tag order, out_p stable while stalled, in_ready low while stalled and full.
- Reset mid-flight: accept 2 beats, assert rst_n=0 one cycle later -> out_valid=0, busy=0, out_p=0 immediately; after release no stale result appears and the next beat (3*4=12) returns correctly.
- Parameter sweep at WIDTH=8 and WIDTH=32: 10k random signed and unsigned beats checked against a behavioural reference product, with identical 3-cycle latency.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared helpers for the pipelined Vedic multiplier.
// Provides the width helpers used by vedic_mult_pipe and vedic_mult_core,
// and the legality check for WIDTH, which must be a power of 2 and at least 4.
package vedic_pkg;

   localparam int unsigned DEFAULT_WIDTH = 16;
   localparam int unsigned DEFAULT_TAG_W = 4;

   // Product width for a w-bit multiply.
   function automatic int unsigned prod_w(int unsigned w);
      return 2 * w;
   endfunction

   // Half-width used for the four partial products.
   function automatic int unsigned half_w(int unsigned w);
      return w / 2;
   endfunction

   // WIDTH legality: power of two and at least 4.
   function automatic bit width_ok(int unsigned w);
      return (w >= 4) && ((w & (w - 1)) == 0);
   endfunction

endpackage

// File: rtl/vedic_mult_core.sv
// Combinational unsigned NxN -> 2N Vedic multiplier.
// Splits recursively into four N/2 cores plus an adder tree. The 2x2 base case
// is built from AND gates and half adders.
// Ports: a, b (N-bit operands), p (2N-bit product).
module vedic_mult_core
   import vedic_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);

   if (N == 2) begin : g_base
      logic t0, t1, t2, t3, s1, c1, s2, c2;

      // Vertically-and-crosswise 2x2: two partial-product columns, two half adders.
      assign t0 = a[0] & b[0];
      assign t1 = a[1] & b[0];
      assign t2 = a[0] & b[1];
      assign t3 = a[1] & b[1];
      assign s1 = t1 ^ t2;
      assign c1 = t1 & t2;
      assign s2 = t3 ^ c1;
      assign c2 = t3 & c1;
      assign p  = {c2, s2, s1, t0};
   end else begin : g_split
      localparam int unsigned H = half_w(N);

      logic [N-1:0] ll, hl, lh, hh;

      vedic_mult_core #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
      vedic_mult_core #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl));
      vedic_mult_core #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh));
      vedic_mult_core #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));

      // Adder tree in full 2N width so no carry is lost.
      assign p = {N'(0), ll}
               + {H'(0), hl, H'(0)}
               + {H'(0), lh, H'(0)}
               + {hh, N'(0)};
   end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined signed/unsigned multiplier with valid/ready streams.
// S1 captures sign-stripped magnitudes, S2 holds four half-width Vedic partial
// products, and S3 registers the summed and sign-restored product.
// Ports: clk, rst_n; in_valid/in_ready/in_a/in_b/in_signed/in_tag (operand
// stream); out_valid/out_ready/out_p/out_tag (result stream); busy (any stage
// holds a valid beat).
module vedic_mult_pipe
   import vedic_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned TAG_W = DEFAULT_TAG_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_a,
   input  logic [WIDTH-1:0]      in_b,
   input  logic                  in_signed,
   input  logic [TAG_W-1:0]      in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*WIDTH-1:0]    out_p,
   output logic [TAG_W-1:0]      out_tag,
   output logic                  busy
);

   localparam int unsigned HALF = half_w(WIDTH);
   localparam int unsigned PW   = prod_w(WIDTH);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("vedic_mult_pipe: WIDTH must be a power of 2 and at least 4");
   end

   logic             en;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             neg;

   logic             s1_valid, s1_neg;
   logic [WIDTH-1:0] s1_a, s1_b;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_valid, s2_neg;
   logic [WIDTH-1:0] s2_ll, s2_hl, s2_lh, s2_hh;
   logic [TAG_W-1:0] s2_tag;

   logic [WIDTH-1:0] ll, hl, lh, hh;
   logic [PW-1:0]    mag, prod;

   // Whole pipeline moves together; it stalls only when a result is held.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign busy     = s1_valid || s2_valid || out_valid;

   // Sign stripping; the most negative value maps to 2^(WIDTH-1), which fits unsigned.
   always_comb begin
      a_mag = in_a;
      b_mag = in_b;
      neg   = 1'b0;
      if (in_signed) begin
         if (in_a[WIDTH-1]) a_mag = ~in_a + WIDTH'(1);
         if (in_b[WIDTH-1]) b_mag = ~in_b + WIDTH'(1);
         neg = in_a[WIDTH-1] ^ in_b[WIDTH-1];
      end
   end

   vedic_mult_core #(.N(HALF)) u_ll (.a(s1_a[HALF-1:0]),     .b(s1_b[HALF-1:0]),     .p(ll));
   vedic_mult_core #(.N(HALF)) u_hl (.a(s1_a[WIDTH-1:HALF]), .b(s1_b[HALF-1:0]),     .p(hl));
   vedic_mult_core #(.N(HALF)) u_lh (.a(s1_a[HALF-1:0]),     .b(s1_b[WIDTH-1:HALF]), .p(lh));
   vedic_mult_core #(.N(HALF)) u_hh (.a(s1_a[WIDTH-1:HALF]), .b(s1_b[WIDTH-1:HALF]), .p(hh));

   // Final recombination and sign restore; a zero magnitude stays zero when negated.
   always_comb begin
      mag  = PW'(s2_ll) + (PW'(s2_hl) << HALF) + (PW'(s2_lh) << HALF) + (PW'(s2_hh) << WIDTH);
      prod = s2_neg ? (~mag + PW'(1)) : mag;
   end

   // S1: operand capture. Data registers load only for valid beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_neg   <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_tag   <= '0;
      end else if (en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_neg <= neg;
            s1_a   <= a_mag;
            s1_b   <= b_mag;
            s1_tag <= in_tag;
         end
      end
   end

   // S2: partial products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_neg   <= 1'b0;
         s2_ll    <= '0;
         s2_hl    <= '0;
         s2_lh    <= '0;
         s2_hh    <= '0;
         s2_tag   <= '0;
      end else if (en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_neg <= s1_neg;
            s2_ll  <= ll;
            s2_hl  <= hl;
            s2_lh  <= lh;
            s2_hh  <= hh;
            s2_tag <= s1_tag;
         end
      end
   end

   // S3: output register; holds steady under backpressure and across bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_p     <= '0;
         out_tag   <= '0;
      end else if (en) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            out_p   <= prod;
            out_tag <= s2_tag;
         end
      end
   end

endmodule
